uart_instr_loader: RTL and testbench

//   Parametrised UART program loader: deserialises 8N1 bytes on rx_serial, assembles RV32IC

---
 rtl/uart_instr_loader.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_instr_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_instr_loader.sv
// UART program loader: receives 8N1 bytes, assembles 16/32-bit RV32IC instructions
// little-endian and streams them to the instruction-memory write port. A HALT_WORD
// ends loading with a start pulse. Recovers from framing errors and mid-word idle gaps.
module uart_instr_loader #(
    parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
    parameter int unsigned BAUD         = 115_200,
    parameter int unsigned MEM_BYTES    = 1024,
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_serial,
    output logic [31:0] write_instr_data,
    output logic        write_instr_valid,
    output logic        write_is_compressed,
    output logic [31:0] write_byte_address,
    output logic        start,
    output logic        frame_error,
    output logic        sync_lost,
    output logic        busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned AW           = $clog2(MEM_BYTES);
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned TW           = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} rx_state_e;

    rx_state_e         state_q, state_d;
    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              byte_done, stop_bad, start_edge;

    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       instr_q, instr_d;
    logic              comp_q, comp_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [31:0]       word_c;
    logic              comp_now, complete, timeout_hit;

    logic [31:0]       data_q, data_d, addr_out_q, addr_out_d;
    logic              comp_out_q, comp_out_d;
    logic              wr_q, wr_d, start_q, start_d, ferr_q, ferr_d, sync_q, sync_d;

    // Two-flop synchroniser plus edge history; preset high so release is not a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_serial;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receiver next-state: start validation at half bit, then bit-centre sampling.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_done  = 1'b0;
        stop_bad   = 1'b0;
        start_edge = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_prev_q && !rx_sync_q) begin
                    start_edge = 1'b1;
                    state_d    = StStart;
                    cnt_d      = '0;
                end
            end
            StStart: begin
                if (cnt_q == CW'(HALF_BIT - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = StStop;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_done = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBreak: begin
                if (rx_sync_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Insert the received byte at its little-endian lane; length is fixed by byte 0.
    always_comb begin
        word_c = instr_q;
        word_c[{byte_cnt_q, 3'b000} +: 8] = shift_q;
        comp_now = (byte_cnt_q == 2'd0) ? (shift_q[1:0] != 2'b11) : comp_q;
        complete = byte_done && ((comp_now && byte_cnt_q == 2'd1) || byte_cnt_q == 2'd3);
        // Only fire between bytes so a timeout never coincides with a byte result.
        timeout_hit = (byte_cnt_q != 2'd0) && (timer_q == TW'(TIMEOUT_CLKS - 1)) &&
                      (state_q == StIdle) && !start_edge;
    end

    // Instruction assembly, address advance and registered strobes.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        instr_d    = instr_q;
        comp_d     = comp_q;
        addr_d     = addr_q;
        data_d     = data_q;
        addr_out_d = addr_out_q;
        comp_out_d = comp_out_q;
        wr_d       = 1'b0;
        start_d    = 1'b0;
        ferr_d     = 1'b0;
        sync_d     = 1'b0;
        if (byte_cnt_q == 2'd0 || start_edge)          timer_d = '0;
        else if (timer_q != TW'(TIMEOUT_CLKS - 1))      timer_d = timer_q + 1'b1;
        else                                           timer_d = timer_q;

        if (stop_bad) begin
            ferr_d     = 1'b1;
            byte_cnt_d = '0;
        end else if (byte_done) begin
            instr_d = word_c;
            comp_d  = comp_now;
            if (complete) begin
                byte_cnt_d = '0;
                if (!comp_now && word_c == HALT_WORD) begin
                    start_d = 1'b1;
                    addr_d  = '0;
                end else begin
                    wr_d       = 1'b1;
                    data_d     = comp_now ? {16'h0000, word_c[15:0]} : word_c;
                    comp_out_d = comp_now;
                    addr_out_d = 32'(addr_q);
                    addr_d     = addr_q + (comp_now ? AW'(2) : AW'(4));
                end
            end else begin
                byte_cnt_d = byte_cnt_q + 1'b1;
            end
        end else if (timeout_hit) begin
            sync_d     = 1'b1;
            byte_cnt_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            instr_q    <= '0;
            comp_q     <= 1'b0;
            addr_q     <= '0;
            timer_q    <= '0;
            data_q     <= '0;
            addr_out_q <= '0;
            comp_out_q <= 1'b0;
            wr_q       <= 1'b0;
            start_q    <= 1'b0;
            ferr_q     <= 1'b0;
            sync_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            instr_q    <= instr_d;
            comp_q     <= comp_d;
            addr_q     <= addr_d;
            timer_q    <= timer_d;
            data_q     <= data_d;
            addr_out_q <= addr_out_d;
            comp_out_q <= comp_out_d;
            wr_q       <= wr_d;
            start_q    <= start_d;
            ferr_q     <= ferr_d;
            sync_q     <= sync_d;
        end
    end

    assign write_instr_data    = data_q;
    assign write_instr_valid   = wr_q;
    assign write_is_compressed = comp_out_q;
    assign write_byte_address  = addr_out_q;
    assign start               = start_q;
    assign frame_error         = ferr_q;
    assign sync_lost           = sync_q;
    assign busy                = (state_q != StIdle) || (byte_cnt_q != 2'd0);

endmodule

// File: tb/tb_uart_instr_loader.sv
// Bench for uart_instr_loader: directed vector table, hand-written corner sequences
// and a random byte stream checked against a byte-stream reference model.
module tb_uart_instr_loader;

    localparam int unsigned CPB = 4;
    localparam int unsigned MEM = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_serial = 1'b1;
    logic [31:0] write_instr_data;
    logic        write_instr_valid;
    logic        write_is_compressed;
    logic [31:0] write_byte_address;
    logic        start;
    logic        frame_error;
    logic        sync_lost;
    logic        busy;

    uart_instr_loader #(
        .CLK_FREQ_HZ (400_000),
        .BAUD        (100_000),
        .MEM_BYTES   (MEM),
        .HALT_WORD   (32'hFFFF_FFFF),
        .TIMEOUT_BITS(40)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rx_serial          (rx_serial),
        .write_instr_data   (write_instr_data),
        .write_instr_valid  (write_instr_valid),
        .write_is_compressed(write_is_compressed),
        .write_byte_address (write_byte_address),
        .start              (start),
        .frame_error        (frame_error),
        .sync_lost          (sync_lost),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    // Event kinds: 0 none, 1 write, 2 start, 3 frame error, 4 sync lost.
    typedef struct {
        int          kind;
        logic [31:0] data;
        logic        comp;
        logic [31:0] addr;
        int          nstrobe;
    } ev_t;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        int          nb;
        bit          stop_ok;
        int          kind;
        logic [31:0] data;
        logic        comp;
        logic [31:0] addr;
    } vec_t;

    ev_t obs_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    // Reference model state: pending bytes of the current instruction and next address.
    logic [7:0]  m_pend[$];
    int unsigned m_addr;

    // Capture every strobe cycle, away from the active edge.
    always @(negedge clk) begin : mon
        ev_t e;
        int  n;
        n = int'(write_instr_valid) + int'(start) + int'(frame_error) + int'(sync_lost);
        if (rst && n != 0) begin
            e.kind    = write_instr_valid ? 1 : start ? 2 : frame_error ? 3 : 4;
            e.data    = write_instr_data;
            e.comp    = write_is_compressed;
            e.addr    = write_byte_address;
            e.nstrobe = n;
            obs_q.push_back(e);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap_bits);
        @(negedge clk);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_serial = stop_ok;
        repeat (CPB) @(negedge clk);
        rx_serial = 1'b1;
        repeat (gap_bits * CPB) @(negedge clk);
    endtask

    task automatic expect_ev(input string name, input int kind, input logic [31:0] data,
                             input logic comp, input logic [31:0] addr);
        ev_t e;
        int  waited = 0;
        while (obs_q.size() == 0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (obs_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: no strobe within budget, expected kind %0d", name, kind);
            return;
        end
        e = obs_q.pop_front();
        check({name, " kind"}, 32'(e.kind), 32'(kind));
        check({name, " exclusive"}, 32'(e.nstrobe), 32'd1);
        if (kind == 1) begin
            check({name, " data"}, e.data, data);
            check({name, " comp"}, {31'd0, e.comp}, {31'd0, comp});
            check({name, " addr"}, e.addr, addr);
        end
    endtask

    task automatic expect_none(input string name);
        repeat (3) @(negedge clk);
        check({name, " no strobe"}, obs_q.size(), 32'd0);
        obs_q.delete();
    endtask

    // Model: collect bytes, length from byte 0, emit write or start when complete.
    task automatic model_byte(input logic [7:0] b, output int kind, output logic [31:0] data,
                              output logic comp, output logic [31:0] addr);
        int          len;
        logic [31:0] word;
        kind = 0; data = '0; comp = 1'b0; addr = '0;
        m_pend.push_back(b);
        len = (m_pend[0][1:0] == 2'b11) ? 4 : 2;
        if (m_pend.size() == len) begin
            word = '0;
            for (int i = 0; i < len; i++) word = word | (32'(m_pend[i]) << (8 * i));
            m_pend.delete();
            if (len == 4 && word == 32'hFFFF_FFFF) begin
                kind   = 2;
                m_addr = 0;
            end else begin
                kind   = 1;
                data   = word;
                comp   = (len == 2);
                addr   = m_addr;
                m_addr = (m_addr + len) % MEM;
            end
        end
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        vec_t        tbl[14];
        logic [7:0]  bs[4];
        int          kind;
        logic [31:0] d, a;
        logic        c;
        logic [7:0]  rb;

        tbl[0]  = '{8'h13, 8'h00, 8'h00, 8'h00, 4, 1'b1, 1, 32'h0000_0013, 1'b0, 32'd0};
        tbl[1]  = '{8'h01, 8'h00, 8'h00, 8'h00, 2, 1'b1, 1, 32'h0000_0001, 1'b1, 32'd4};
        tbl[2]  = '{8'h13, 8'h00, 8'h10, 8'h00, 4, 1'b1, 1, 32'h0010_0013, 1'b0, 32'd6};
        tbl[3]  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 4, 1'b1, 2, 32'h0, 1'b0, 32'd0};
        tbl[4]  = '{8'h13, 8'h00, 8'h00, 8'h00, 4, 1'b1, 1, 32'h0000_0013, 1'b0, 32'd0};
        tbl[5]  = '{8'hAA, 8'h00, 8'h00, 8'h00, 1, 1'b0, 3, 32'h0, 1'b0, 32'd0};
        tbl[6]  = '{8'h93, 8'h00, 8'h00, 8'h00, 4, 1'b1, 1, 32'h0000_0093, 1'b0, 32'd4};
        tbl[7]  = '{8'h02, 8'h40, 8'h00, 8'h00, 2, 1'b1, 1, 32'h0000_4002, 1'b1, 32'd8};
        tbl[8]  = '{8'hFF, 8'hFF, 8'hFF, 8'h7F, 4, 1'b1, 1, 32'h7FFF_FFFF, 1'b0, 32'd10};
        tbl[9]  = '{8'hFD, 8'hFF, 8'h00, 8'h00, 2, 1'b1, 1, 32'h0000_FFFD, 1'b1, 32'd14};
        tbl[10] = '{8'h13, 8'h00, 8'h00, 8'h00, 2, 1'b1, 0, 32'h0, 1'b0, 32'd0};
        tbl[11] = '{8'h55, 8'h00, 8'h00, 8'h00, 1, 1'b0, 3, 32'h0, 1'b0, 32'd0};
        tbl[12] = '{8'h37, 8'h12, 8'h00, 8'h00, 4, 1'b1, 1, 32'h0000_1237, 1'b0, 32'd16};
        tbl[13] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 4, 1'b1, 2, 32'h0, 1'b0, 32'd0};

        // Reset state.
        #3 rst = 1'b0;
        #1;
        check("reset data", write_instr_data, 32'd0);
        check("reset valid", {31'd0, write_instr_valid}, 32'd0);
        check("reset comp", {31'd0, write_is_compressed}, 32'd0);
        check("reset addr", write_byte_address, 32'd0);
        check("reset start", {31'd0, start}, 32'd0);
        check("reset ferr", {31'd0, frame_error}, 32'd0);
        check("reset sync", {31'd0, sync_lost}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 14; i++) begin
            bs[0] = tbl[i].b0; bs[1] = tbl[i].b1; bs[2] = tbl[i].b2; bs[3] = tbl[i].b3;
            for (int j = 0; j < tbl[i].nb; j++) send_byte(bs[j], tbl[i].stop_ok, 2);
            if (tbl[i].kind == 0) begin
                expect_none($sformatf("vec%0d", i));
            end else begin
                expect_ev($sformatf("vec%0d", i), tbl[i].kind, tbl[i].data, tbl[i].comp,
                          tbl[i].addr);
                if (tbl[i].kind != 1) expect_none($sformatf("vec%0d tail", i));
            end
        end

        // Idle timeout discards a partial 32-bit instruction.
        send_byte(8'h03, 1'b1, 1);
        send_byte(8'h00, 1'b1, 0);
        check("partial busy", {31'd0, busy}, 32'd1);
        repeat (45 * CPB) @(negedge clk);
        expect_ev("timeout", 4, 32'd0, 1'b0, 32'd0);
        check("timeout busy", {31'd0, busy}, 32'd0);
        for (int j = 0; j < 4; j++) send_byte(j == 0 ? 8'h13 : 8'h00, 1'b1, 1);
        expect_ev("post timeout", 1, 32'h0000_0013, 1'b0, 32'd0);

        // One-clock glitch must be rejected as a start bit.
        @(negedge clk) rx_serial = 1'b0;
        @(negedge clk) rx_serial = 1'b1;
        repeat (20) @(negedge clk);
        expect_none("glitch");
        check("glitch busy", {31'd0, busy}, 32'd0);

        // Random byte stream against the model, with occasional framing errors.
        m_addr = 4;
        m_pend.delete();
        for (int n = 0; n < 120; n++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                send_byte(rb, 1'b0, 2);
                m_pend.delete();
                expect_ev("rnd ferr", 3, 32'd0, 1'b0, 32'd0);
            end else begin
                send_byte(rb, 1'b1, $urandom_range(0, 8));
                model_byte(rb, kind, d, c, a);
                if (kind == 0) expect_none("rnd byte");
                else           expect_ev("rnd instr", kind, d, c, a);
            end
        end
        repeat (45 * CPB) @(negedge clk);
        if (m_pend.size() != 0) begin
            expect_ev("rnd timeout", 4, 32'd0, 1'b0, 32'd0);
            m_pend.delete();
        end else begin
            expect_none("rnd idle");
        end

        // Address wrap: 256 words fill memory, the 257th lands at 0.
        for (int j = 0; j < 4; j++) send_byte(8'hFF, 1'b1, 0);
        expect_ev("wrap halt", 2, 32'd0, 1'b0, 32'd0);
        for (int w = 0; w < 257; w++) begin
            send_byte(8'h13, 1'b1, 0);
            send_byte(8'(w), 1'b1, 0);
            send_byte({7'd0, w[8]}, 1'b1, 0);
            send_byte(8'h00, 1'b1, 0);
            expect_ev($sformatf("wrap%0d", w), 1, {15'd0, w[8:0], 8'h13}, 1'b0,
                      32'((w * 4) % MEM));
        end
        for (int j = 0; j < 4; j++) send_byte(j == 0 ? 8'h37 : 8'h00, 1'b1, 1);
        expect_ev("after wrap", 1, 32'h0000_0037, 1'b0, 32'd4);

        // Reset mid-instruction and mid-byte.
        send_byte(8'h13, 1'b1, 1);
        send_byte(8'h00, 1'b1, 1);
        rx_serial = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst data", write_instr_data, 32'd0);
        check("midrst addr", write_byte_address, 32'd0);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst strobes", {28'd0, write_instr_valid, start, frame_error, sync_lost},
              32'd0);
        rx_serial = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        expect_none("post reset idle");
        check("post reset busy", {31'd0, busy}, 32'd0);
        for (int j = 0; j < 4; j++) send_byte(j == 0 ? 8'h13 : 8'h00, 1'b1, 1);
        expect_ev("post reset write", 1, 32'h0000_0013, 1'b0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
